otter_cu_fsm: RTL
=================

// Module: otter_cu_fsm
// PURPOSE
//   Multicycle control unit for the Otter MCU. Sequences the program counter register
//   (pc_write enable, pc_reset), instruction/data memory strobes, register-file and
//   CSR writes, and interrupt entry. Sits between instruction decode and the PC/memory
//   datapath. Stalls on a memory-ready handshake, with a bounded timeout.
// PARAMETERS
//   INIT_CYCLES   2   cycles spent in INIT (PC held in reset) after reset_n deasserts; >=1
//   WAIT_TIMEOUT  15  consecutive mem_ready=0 cycles in FETCH/WB before FAULT; >=1
// PORTS
//   clk        in   1  system clock, all state on rising edge
//   reset_n    in   1  asynchronous, active-low reset
//   ir_opcode  in   7  opcode field of current instruction (valid in EXEC)
//   ir_func3   in   3  func3 field of current instruction (valid in EXEC)
//   intr       in   1  interrupt request, level, already synchronised
//   mie        in   1  machine interrupt enable from CSR file
//   mem_ready  in   1  memory completed current read (FETCH: instr, WB: load data)
//   pc_reset   out  1  synchronous reset request to PC register
//   pc_write   out  1  PC register load enable (1-cycle pulse per instruction)
//   reg_write  out  1  register-file write enable
//   mem_rden1  out  1  instruction-port read enable
//   mem_rden2  out  1  data-port read enable
//   mem_we2    out  1  data-port write enable
//   csr_we     out  1  CSR write enable
//   int_taken  out  1  interrupt entry; PC mux selects mtvec this cycle
//   fault      out  1  sticky fault flag
//   fault_code out  2  00 none, 01 memory timeout, 10 illegal opcode
//   fsm_state  out  3  debug: INIT=0 FETCH=1 EXEC=2 WB=3 INTR=4 FAULT=5
// BEHAVIOUR
//   - Reset (reset_n=0, async): state=INIT, init/wait counters=0, fault=0, fault_code=00.
//     All strobes 0 except pc_reset=1.
//   - Strobes are combinational from state and inputs. All are 0 unless listed below.
//   - INIT: pc_reset=1. Stay INIT_CYCLES cycles, then go to FETCH.
//   - FETCH: mem_rden1=1. On mem_ready=1, go to EXEC.
//   - EXEC, decode on ir_opcode:
//     - LOAD 0000011: mem_rden2=1, go to WB. No pc_write.
//     - STORE 0100011: mem_we2=1, pc_write=1.
//     - BRANCH 1100011: pc_write=1.
//     - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP 0110011,
//       OP-IMM 0010011: reg_write=1, pc_write=1.
//     - SYSTEM 1110011, func3!=000: csr_we=1, reg_write=1, pc_write=1.
//     - SYSTEM 1110011, func3=000 (mret): pc_write=1 only.
//     - Any other opcode: all strobes 0, go to FAULT, fault_code=10.
//   - WB: mem_rden2=1 held. On mem_ready=1: reg_write=1, pc_write=1.
//   - Instruction boundary = EXEC commit (non-LOAD, legal) or WB commit.
//     Next state is INTR if intr&mie at that edge, else FETCH.
//     intr is ignored in all other states.
//   - INTR: one cycle, int_taken=1, pc_write=1, csr_we=0, then FETCH.
//   - Timeout counter wait_cnt:
//     - Cleared on entry to FETCH/WB; +1 each FETCH/WB cycle with mem_ready=0.
//     - mem_ready=0 with wait_cnt==WAIT_TIMEOUT-1: go to FAULT, fault_code=01.
//     - mem_ready=1 in that same cycle wins: normal transition, no fault.
//   - FAULT: absorbing. All strobes 0, fault=1, fault_code held until reset_n=0.
//   - Exactly one pc_write pulse per retired instruction or interrupt entry.
//     pc_write is never asserted in INIT, FETCH or FAULT.
//   - reset_n asserted mid-instruction: immediate return to INIT, pending writes dropped.
// TESTING
//   1. Reset: reset_n=0 -> pc_reset=1, all other strobes 0.
//      Release -> pc_reset=1 for 2 cycles, then FETCH with mem_rden1=1.
//   2. OP-IMM 0010011, mem_ready always 1 -> FETCH,EXEC repeat every 2 cycles;
//      reg_write and pc_write pulse in EXEC only.
//   3. LOAD with mem_ready low 3 cycles in WB -> WB lasts 4 cycles;
//      reg_write and pc_write pulse once, in the final WB cycle.
//   4. intr=1, mie=1 during EXEC of BRANCH -> next state INTR;
//      int_taken and pc_write high 1 cycle, then FETCH.
//      Same with mie=0 -> FETCH, int_taken never asserted.
//   5. mem_ready held 0 in FETCH -> FAULT after 15 cycles, fault_code=01.
//      mem_ready=1 on the 15th cycle -> EXEC, no fault.
//   6. Opcode 0000000 in EXEC -> FAULT, fault_code=10, no strobes;
//      then reset_n=0 pulse -> INIT, fault=0.

Source files
------------

// File: rtl/otter_cu_fsm.sv
// Multicycle control unit for the Otter MCU.
// Sequences PC reset/load, instruction and data memory strobes, register-file
// and CSR writes, and interrupt entry. A bounded wait on mem_ready in FETCH and
// WB prevents a dead memory from hanging the core; that case, and an illegal
// opcode, park the unit in an absorbing FAULT state until reset.
module otter_cu_fsm #(
    parameter int INIT_CYCLES  = 2,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] ir_opcode,
    input  logic [2:0] ir_func3,
    input  logic       intr,
    input  logic       mie,
    input  logic       mem_ready,
    output logic       pc_reset,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       csr_we,
    output logic       int_taken,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] fsm_state
);

    // Counter widths sized to hold the largest value each counter reaches.
    localparam int INIT_W = (INIT_CYCLES  > 1) ? $clog2(INIT_CYCLES)  : 1;
    localparam int WAIT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    // RV32I major opcodes recognised by the decoder.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_ILLEGAL = 2'b10;

    // Encodings are visible on fsm_state for debug, so they are fixed.
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_INTR  = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    state_e            state_q,      state_d;
    logic [INIT_W-1:0] init_cnt_q,   init_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic [1:0]        fault_code_q, fault_code_d;

    // Where an instruction goes once it retires: interrupt entry wins if enabled.
    state_e boundary_next;
    assign boundary_next = (intr && mie) ? S_INTR : S_FETCH;

    // State, counters and fault code; reset returns to INIT and drops all pending work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state decode and combinational strobes from current state and inputs.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        fault_code_d = fault_code_q;
        pc_reset     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        mem_rden1    = 1'b0;
        mem_rden2    = 1'b0;
        mem_we2      = 1'b0;
        csr_we       = 1'b0;
        int_taken    = 1'b0;

        unique case (state_q)
            S_INIT: begin
                pc_reset = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end

            S_FETCH: begin
                mem_rden1 = 1'b1;
                // A ready in the last allowed cycle still counts as success.
                if (mem_ready) begin
                    state_d = S_EXEC;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_EXEC: begin
                unique case (ir_opcode)
                    OPC_LOAD: begin
                        // PC advances only once the load data is written back.
                        mem_rden2 = 1'b1;
                        state_d   = S_WB;
                    end
                    OPC_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = 1'b1;
                        state_d  = boundary_next;
                    end
                    OPC_BRANCH: begin
                        pc_write = 1'b1;
                        state_d  = boundary_next;
                    end
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        state_d   = boundary_next;
                    end
                    OPC_SYSTEM: begin
                        // func3 == 000 is mret: it only redirects the PC.
                        if (ir_func3 != 3'b000) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end
                        pc_write = 1'b1;
                        state_d  = boundary_next;
                    end
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = FC_ILLEGAL;
                    end
                endcase
            end

            S_WB: begin
                mem_rden2 = 1'b1;
                if (mem_ready) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = boundary_next;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_INTR: begin
                // PC loads mtvec this cycle; the CSR file saves context on int_taken.
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Every fresh entry into a memory-wait state starts a new timeout window.
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_WB))) begin
            wait_cnt_d = '0;
        end
    end

    assign fault      = (state_q == S_FAULT);
    assign fault_code = fault_code_q;
    assign fsm_state  = state_q;

endmodule
